// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_pkg
// Description : Shared types and helpers for the multi-cycle shift sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_seq_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of log stages needed for a word whose MSB index is n
    function automatic int stage_count(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : shift_seq_pkg
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage
// Description : One combinational log stage; shifts or rotates by 2^K when
//               enabled, otherwise passes the word through unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_stage #(
    parameter int N = 7,
    parameter int K = 0
) (
    input  logic [N:0] data,
    input  logic       en,
    input  logic       dir,
    input  logic       rot,
    output logic [N:0] result
);

    localparam int c_width = N + 1;
    localparam int c_dist  = 1 << K;

    logic [N:0] w_left;
    logic [N:0] w_right;

    // Build both directions, fold in the wrapped bits for rotate, then select
    always_comb begin
        w_left  = data << c_dist;
        w_right = data >> c_dist;
        if (rot) begin
            w_left  = w_left  | (data >> (c_width - c_dist));
            w_right = w_right | (data << (c_width - c_dist));
        end
        result = data;
        if (en) begin
            result = dir ? w_right : w_left;
        end
    end

endmodule : shift_stage
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Accepts one shift/rotate request, applies one log stage per
//               clock, then holds the result until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter  int N      = 7,
    localparam int STAGES = stage_count(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N:0]        in_data,
    input  logic [STAGES-1:0] in_amt,
    input  logic              in_dir,
    input  logic              in_rot,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N:0]        out_data,
    output logic              busy,
    output logic [STAGES-1:0] stage
);

    localparam logic [STAGES-1:0] c_last_stage = STAGES'(STAGES - 1);
    localparam logic [STAGES-1:0] c_one        = STAGES'(1);

    state_t            r_state;
    logic [STAGES-1:0] r_cnt;
    logic [N:0]        r_data;
    logic [STAGES-1:0] r_amt;
    logic              r_dir;
    logic              r_rot;
    logic [N:0]        r_out_data;

    logic [N:0]        w_stage_out [STAGES];
    logic [N:0]        w_next_data;

    // One instance per log stage; stage k is enabled by amount bit k
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        shift_stage #(
            .N (N),
            .K (k)
        ) u_stage (
            .data   (r_data),
            .en     (r_amt[k]),
            .dir    (r_dir),
            .rot    (r_rot),
            .result (w_stage_out[k])
        );
    end

    assign w_next_data = w_stage_out[r_cnt];

    // Control FSM, stage counter and data registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_data     <= '0;
            r_amt      <= '0;
            r_dir      <= 1'b0;
            r_rot      <= 1'b0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_amt   <= in_amt;
                        r_dir   <= in_dir;
                        r_rot   <= in_rot;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_data <= w_next_data;
                    if (r_cnt == c_last_stage) begin
                        // Counter parks at zero so the stage output reads 0 outside SHIFT
                        r_cnt      <= '0;
                        r_out_data <= w_next_data;
                        r_state    <= DONE;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Status outputs decode the state register only
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
        stage     = r_cnt;
        out_data  = r_out_data;
    end

endmodule : shift_sequencer
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Self-checking bench for shift_sequencer (N = 7).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    localparam int N      = 7;
    localparam int W      = N + 1;
    localparam int STAGES = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [N:0]        in_data;
    logic [STAGES-1:0] in_amt;
    logic              in_dir;
    logic              in_rot;
    logic              out_valid;
    logic              out_ready;
    logic [N:0]        out_data;
    logic              busy;
    logic [STAGES-1:0] stage;

    int total = 0;
    int bad   = 0;

    shift_sequencer #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_rot    (in_rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .stage     (stage)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-level reference: result bit i takes source bit i-a (left) or i+a (right)
    function automatic logic [N:0] ref_shift(input logic [N:0] d, input int a,
                                             input bit dir, input bit rot);
        logic [N:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            int src;
            src = dir ? i + a : i - a;
            if (rot) src = (src + W) % W;
            if (src >= 0 && src < W) r[i] = d[src];
        end
        return r;
    endfunction

    // Full transaction: request, latency/stage tracking, optional backpressure
    task automatic do_op(input logic [N:0] d, input logic [STAGES-1:0] a,
                         input bit dr, input bit rt, input int hold, input bit poke);
        logic [N:0] exp;
        int n;
        exp = ref_shift(d, int'(a), dr, rt);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check_val("ready_before_req", {31'd0, in_ready}, 32'd1);
        in_data  = d;
        in_amt   = a;
        in_dir   = dr;
        in_rot   = rt;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = N'($urandom);
        in_amt   = STAGES'($urandom);
        in_dir   = 1'($urandom);
        in_rot   = 1'($urandom);
        check_val("accept_busy", {31'd0, busy}, 32'd1);
        check_val("accept_ready_low", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 10) begin
            check_val("stage_idx", {29'd0, stage}, n);
            tick();
            n++;
        end
        check_val("latency", n, 32'd3);
        check_val("result", {24'd0, out_data}, {24'd0, exp});
        check_val("stage_in_done", {29'd0, stage}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                in_valid = 1'b1;
                in_data  = ~d;
            end
            tick();
            check_val("hold_valid", {31'd0, out_valid}, 32'd1);
            check_val("hold_data", {24'd0, out_data}, {24'd0, exp});
            check_val("hold_ready_low", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check_val("post_hs_ready", {31'd0, in_ready}, 32'd1);
        check_val("idle_keeps_data", {24'd0, out_data}, {24'd0, exp});
    endtask

    initial begin
        int times [2];
        logic [N:0] res [2];
        int nres;
        int cyc;
        bit drop;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        in_amt    = 3'd2;
        in_dir    = 1'b0;
        in_rot    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        check_val("rst_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_stage", {29'd0, stage}, 32'd0);
        check_val("rst_data", {24'd0, out_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed cases from the plan
        check_val("ref_lsl3", {24'd0, ref_shift(8'b00010111, 3, 0, 0)}, 32'b10111000);
        do_op(8'b00010111, 3'd3, 1'b0, 1'b0, 0, 1'b0);
        do_op(8'b00010111, 3'd1, 1'b1, 1'b1, 0, 1'b0);
        do_op(8'b10000001, 3'd7, 1'b0, 1'b1, 0, 1'b0);
        do_op(8'b00010111, 3'd5, 1'b1, 1'b0, 0, 1'b0);
        do_op(8'b01101001, 3'd0, 1'b1, 1'b1, 0, 1'b0);

        // Backpressure with ignored request pulses
        do_op(8'b11001010, 3'd6, 1'b1, 1'b1, 4, 1'b1);

        // Reset during stage 1, with a request presented on the reset edge
        in_data  = 8'h3C;
        in_amt   = 3'd4;
        in_dir   = 1'b0;
        in_rot   = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check_val("mid_stage", {29'd0, stage}, 32'd1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check_val("midrst_ready", {31'd0, in_ready}, 32'd1);
        check_val("midrst_valid", {31'd0, out_valid}, 32'd0);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_data", {24'd0, out_data}, 32'd0);
        check_val("midrst_stage", {29'd0, stage}, 32'd0);
        do_op(8'h3C, 3'd4, 1'b0, 1'b1, 1, 1'b0);

        // Back-to-back with in_valid held and out_ready tied high
        out_ready = 1'b1;
        in_data   = 8'b11100001;
        in_amt    = 3'd2;
        in_dir    = 1'b1;
        in_rot    = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_data = 8'b00110101;
        in_amt  = 3'd5;
        in_dir  = 1'b0;
        in_rot  = 1'b1;
        nres    = 0;
        cyc     = 0;
        times   = '{0, 0};
        res     = '{8'd0, 8'd0};
        while (nres < 2 && cyc < 30) begin
            drop = in_ready && in_valid;
            tick();
            cyc++;
            if (drop) in_valid = 1'b0;
            if (out_valid) begin
                times[nres] = cyc;
                res[nres]   = out_data;
                nres++;
            end
        end
        tick();
        out_ready = 1'b0;
        check_val("b2b_count", nres, 32'd2);
        check_val("b2b_first_lat", times[0], 32'd3);
        check_val("b2b_spacing", times[1] - times[0], 32'd5);
        check_val("b2b_res0", {24'd0, res[0]}, {24'd0, ref_shift(8'b11100001, 2, 1, 0)});
        check_val("b2b_res1", {24'd0, res[1]}, {24'd0, ref_shift(8'b00110101, 5, 0, 1)});

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            do_op(N'($urandom), STAGES'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_sequencer
`default_nettype wire

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller for a W = N+1 bit logarithmic shift/rotate datapath. It accepts one shift request over a valid/ready handshake and applies one log stage per clock: stage k shifts by 2^k when amount bit k is set. It then holds the result on a valid/ready output until it is consumed. It sits between a requester (bus bridge or test sequencer) and the shared shift register, and replaces purely combinational use of the shifter where timing closure requires one stage per cycle.

## Interface
- N, default 7: MSB index of the data word; W = N+1 must be a power of two, W ≥ 2.
- STAGES, derived localparam = $clog2(N+1) (3 for N=7); not overridable.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- in_data  input  [N:0]  word to shift.
- in_amt  input  [STAGES-1:0]  shift amount, 0..N.
- in_dir  input  1  0 = left, 1 = right.
- in_rot  input  1  0 = logical (zero fill), 1 = rotate.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  [N:0]  shifted word.
- busy  output  1  high in SHIFT or DONE.
- stage  output  [STAGES-1:0]  index of the stage applied on the next edge; 0 outside SHIFT.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1, the block latches in_data, in_amt, in_dir and in_rot, clears the stage counter and enters SHIFT.
- SHIFT: in_ready=0. Each edge applies stage k = counter to the data register, then increments the counter. After the stage STAGES-1 edge, the block enters DONE.
- Stage k with amt[k]=0 leaves the register unchanged. The edge is still consumed, so latency is fixed regardless of amount; in_amt=0 returns in_data unchanged.
- Logical shift: vacated bits are 0. Rotate: bits wrap around modulo W.
- DONE: out_valid=1 and out_data is held stable. On an edge with out_ready=1, the block returns to IDLE. out_data keeps its last value in IDLE.
- in_valid while busy is ignored; no request is queued.
- out_ready outside DONE is ignored.
- The block never drops a result: it stays in DONE indefinitely while out_ready=0.

## Timing
- Reset (rst_n=0 at an edge, in any state, including mid-SHIFT): state=IDLE, data register and out_data=0, counter=0, in_ready=1, out_valid=0, busy=0, stage=0. An in-flight operation is discarded without out_valid.
- If rst_n=0 and in_valid=1 on the same edge, reset wins and nothing is accepted.
- Latency:
  - Acceptance edge E0.
  - Shift edges E1..E_STAGES.
  - out_valid is high in the cycle after E_STAGES: 3 cycles after acceptance for N=7.
- in_ready rises in the cycle after the output handshake edge; there is no same-cycle bypass. Peak throughput is one operation per STAGES+2 cycles (5 for N=7).
- All outputs are registered or decoded from state only; no combinational path from any input to any output.

## Structure
- Package shift_seq_pkg:
  - state enum {IDLE, SHIFT, DONE} as logic [1:0].
  - function stage_count(n) returning $clog2(n+1).
- Sub-module shift_stage: purely combinational single log stage.
  - Parameters N and K.
  - Inputs: data, en, dir, rot. Output: data shifted/rotated by 2^K when en=1.
- Top level holds FSM, counter and data register, and selects the stage output by counter via a generate array of STAGES shift_stage instances.

## Test plan
- Logical left: data 8'b00010111, amt 3, dir 0, rot 0 -> out_data 8'b10111000, out_valid exactly 3 cycles after acceptance.
- Rotate right: data 8'b00010111, amt 1, dir 1, rot 1 -> out_data 8'b10001011.
- Boundary amounts:
  - data 8'b10000001, amt 7, rotate left -> 8'b11000000.
  - data 8'b00010111, amt 5, logical right -> 8'b00000000.
  - amt 0 -> data unchanged, same latency.
- Backpressure: hold out_ready=0 for 4 cycles in DONE -> out_valid and out_data stable throughout. Pulse in_valid with new data meanwhile -> not accepted, in_ready stays 0. Release out_ready -> in_ready=1 in the next cycle.
- Reset mid-operation: rst_n=0 during stage 1 -> next cycle IDLE, out_data=0, out_valid=0, in_ready=1. A following request completes normally.
- Back-to-back: two requests with in_valid held and out_ready tied 1 -> results spaced exactly 5 cycles apart, both correct.
